aes_round_key_store: RTL and testbench
======================================

# aes_round_key_store

Round-key buffer directly downstream of the AES-128 key expansion stage. Captures the 11 round keys (round 0..10) as the expansion stage emits them, one per cycle, under the core FSM's key-expansion phase. Then serves them to the cipher datapath through a registered read port, in forward (encrypt) or reverse (decrypt) order. Tracks per-slot validity and signals when the full schedule is available.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one key word
- NUM_ROUNDS, 10, last round index; the store holds NUM_ROUNDS+1 slots

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- FSM_core_in  in  3  core phase code: 3'b001 = receive key, 3'b010 = key expansion, others = idle/cipher
- core_count_in  in  4  round index of the key currently presented
- key_in_0..key_in_3  in  DATA_WIDTH each  round-key words from the expansion stage (word 0 = MSW)
- rd_en  in  1  read request
- rd_addr  in  4  requested round index
- rd_rev  in  1  1 = reverse addressing: physical slot = NUM_ROUNDS − rd_addr
- rd_valid  out  1  read data valid, one-cycle pulse
- rd_key_0..rd_key_3  out  DATA_WIDTH each  read data
- rd_err  out  1  one-cycle pulse: read of an invalid or out-of-range slot
- keys_ready  out  1  all NUM_ROUNDS+1 slots valid

## Operation
- Storage: NUM_ROUNDS+1 slots × 4 words, plus a NUM_ROUNDS+1-bit valid vector and a 4-bit fill counter.
- Write: on every cycle with FSM_core_in == 3'b010 and core_count_in ≤ NUM_ROUNDS, key_in_0..3 are written to slot core_count_in and its valid bit is set. core_count_in > NUM_ROUNDS is ignored.
- Rewrite of an already-valid slot overwrites its data. The valid bit stays set and the fill counter does not increment.
- Clear: FSM_core_in == 3'b001 clears all valid bits and the fill counter, and the state goes to EMPTY. This takes priority over everything except rst.
- State machine:
  - EMPTY: leaves to FILLING on the first accepted write.
  - FILLING: goes to READY when the fill counter reaches NUM_ROUNDS+1.
  - READY: stays until cleared.
  - Any state goes to EMPTY on clear.
  - keys_ready = (state == READY), registered.
- Read:
  - When rd_en = 1, the physical slot is rd_addr, or NUM_ROUNDS − rd_addr if rd_rev = 1.
  - If rd_addr > NUM_ROUNDS or the slot is invalid, rd_err pulses and rd_key_* return 0.
  - Otherwise rd_key_* are loaded with the slot data and rd_valid pulses.
  - When rd_en = 0, rd_key_* hold their last value and rd_valid = 0.
- Simultaneous write and read of the same slot: the read returns the pre-write contents and pre-write validity (read-before-write).
- Simultaneous clear and read: the read uses the pre-clear valid bits and data.

## Timing
- Reset values: all outputs 0; storage, valid vector and fill counter 0; state EMPTY.
- Write latency: data is readable on a read issued the cycle after the write.
- Read latency: 1 cycle. A request at edge N produces rd_valid/rd_err and rd_key_* after edge N. Back-to-back reads are allowed every cycle.
- keys_ready rises 1 cycle after the write that completes the fill. It falls 1 cycle after the clear cycle.
- rst asserted mid-fill or mid-read: everything returns to reset values immediately. A pending read produces no rd_valid.

## Configuration
- KEY_STORE_ZEROIZE_EN defined: a clear cycle (FSM_core_in == 3'b001) also zeroes all storage words, so the old key material is unrecoverable.
- KEY_STORE_ZEROIZE_EN undefined: a clear only resets the valid bits and fill counter. Slot data persists until overwritten but is unreadable, because reads of invalid slots return 0 with rd_err.

## Test plan
- Full fill: load FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, expansion counts 0..10 → keys_ready = 1 one cycle after the count-10 write. Forward read rd_addr=1 → a0fafe17 88542cb1 23a33939 2a6c7605, rd_valid pulse after 1 cycle.
- Reverse read: rd_rev=1, rd_addr=0 → round-10 key d014f9a8 c9ee2589 e13f0cc8 b6630ca6. rd_rev=1, rd_addr=10 → 2b7e1516 28aed2a6 abf71588 09cf4f3c.
- Partial fill: write counts 0..4 only, read rd_addr=7 → rd_err = 1, rd_key_* = 0, keys_ready = 0. Read rd_addr=15 → rd_err = 1.
- Collision: slot 3 holds A, write B to slot 3 while reading slot 3 → read returns A; next-cycle read returns B. Fill counter unchanged by the rewrite.
- Clear mid-schedule: after READY, FSM_core_in=3'b001 for one cycle → keys_ready = 0 next cycle, read rd_addr=0 → rd_err. With KEY_STORE_ZEROIZE_EN, internal slot 10 = 0.
- Async reset: assert rst during a fill with a read in flight → all outputs 0 immediately and no rd_valid. After release, state is EMPTY and a read of slot 0 → rd_err.

Source files
------------

// File: rtl/aes_round_key_store.sv
// ---------------------------------------------------------------------------
// aes_round_key_store
//
// Round-key buffer sitting right after the AES-128 key expansion stage.
// While the core is in its key-expansion phase, every presented round key is
// captured into the slot named by core_count_in. Once loaded, the schedule is
// served to the cipher datapath through a registered read port in forward
// (encrypt) or reverse (decrypt) round order.
//
// Optional build macro:
//   KEY_STORE_ZEROIZE_EN - when defined, a clear cycle also wipes every stored
//                          key word. When undefined, a clear only drops the
//                          valid bits and the fill counter. The stale data
//                          stays in place but cannot be read, because reads
//                          of invalid slots return zero with rd_err.
//
// Parameters:
//   DATA_WIDTH     width of one key word
//   NUM_ROUNDS     last round index; NUM_ROUNDS+1 slots are held (max 14)
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   FSM_core_in    core phase: 3'b001 receive key (clear), 3'b010 expansion
//   core_count_in  round index of the key currently presented
//   key_in_0..3    round-key words from the expansion stage (word 0 = MSW)
//   rd_en          read request
//   rd_addr        requested round index
//   rd_rev         1 = reverse addressing (slot = NUM_ROUNDS - rd_addr)
//   rd_valid       one-cycle pulse, read data valid
//   rd_key_0..3    read data (held while rd_en is low)
//   rd_err         one-cycle pulse, read of an invalid or out-of-range slot
//   keys_ready     every slot holds a valid round key
// ---------------------------------------------------------------------------
module aes_round_key_store #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            FSM_core_in,
  input  logic [3:0]            core_count_in,
  input  logic [DATA_WIDTH-1:0] key_in_0,
  input  logic [DATA_WIDTH-1:0] key_in_1,
  input  logic [DATA_WIDTH-1:0] key_in_2,
  input  logic [DATA_WIDTH-1:0] key_in_3,
  input  logic                  rd_en,
  input  logic [3:0]            rd_addr,
  input  logic                  rd_rev,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_key_0,
  output logic [DATA_WIDTH-1:0] rd_key_1,
  output logic [DATA_WIDTH-1:0] rd_key_2,
  output logic [DATA_WIDTH-1:0] rd_key_3,
  output logic                  rd_err,
  output logic                  keys_ready
);

  localparam int         NUM_SLOTS = NUM_ROUNDS + 1;
  localparam logic [3:0] LAST_IDX  = 4'(NUM_ROUNDS);
  localparam logic [3:0] FULL_CNT  = 4'(NUM_SLOTS);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_READY
  } state_e;

  logic [DATA_WIDTH-1:0] keyMem_q [NUM_SLOTS][4];
  logic [DATA_WIDTH-1:0] keyIn    [4];
  logic [NUM_SLOTS-1:0]  valid_q, valid_d;
  logic [3:0]            fillCnt_q, fillCnt_d;
  state_e                state_q, state_d;
  logic                  keysReady_q, keysReady_d;

  logic                  rdValid_q;
  logic                  rdErr_q;
  logic [DATA_WIDTH-1:0] rdKey_q [4];

  logic                  clearReq;
  logic                  wrReq;
  logic                  wrNewSlot;
  logic [3:0]            rdSlot;
  logic                  rdInRange;
  logic                  rdHit;

  assign keyIn[0] = key_in_0;
  assign keyIn[1] = key_in_1;
  assign keyIn[2] = key_in_2;
  assign keyIn[3] = key_in_3;

  // Decode the core phase. Clear and write come from different phase codes,
  // so they can never both be active in the same cycle.
  assign clearReq  = (FSM_core_in == 3'b001);
  assign wrReq     = (FSM_core_in == 3'b010) && (core_count_in <= LAST_IDX);
  assign wrNewSlot = wrReq && !valid_q[core_count_in];

  // Read addressing. The range check uses the raw request, so a reversed
  // request beyond the last round wraps to a bogus slot that is never used.
  assign rdSlot    = rd_rev ? (LAST_IDX - rd_addr) : rd_addr;
  assign rdInRange = (rd_addr <= LAST_IDX);
  assign rdHit     = rdInRange && valid_q[rdSlot];

  // Valid vector and fill counter. A rewrite of an already-valid slot leaves
  // the counter alone, so the counter always equals the number of valid slots.
  always_comb begin
    valid_d   = valid_q;
    fillCnt_d = fillCnt_q;
    if (clearReq) begin
      valid_d   = '0;
      fillCnt_d = '0;
    end else if (wrReq) begin
      valid_d[core_count_in] = 1'b1;
      if (wrNewSlot) begin
        fillCnt_d = fillCnt_q + 4'd1;
      end
    end
  end

  // FSM state register together with the bookkeeping registers it tracks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      valid_q   <= '0;
      fillCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      fillCnt_q <= fillCnt_d;
    end
  end

  // Next-state logic. The full check looks at the next counter value so the
  // state turns READY on the same edge that stores the final round key.
  always_comb begin
    state_d = state_q;
    if (clearReq) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (wrReq) begin
            state_d = (fillCnt_d == FULL_CNT) ? ST_READY : ST_FILLING;
          end
        end
        ST_FILLING: begin
          if (fillCnt_d == FULL_CNT) begin
            state_d = ST_READY;
          end
        end
        ST_READY: state_d = ST_READY;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Output decode. It is computed from the next state and then registered,
  // so keys_ready is a clean flop output that changes together with state_q.
  always_comb begin
    keysReady_d = (state_d == ST_READY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keysReady_q <= 1'b0;
    end else begin
      keysReady_q <= keysReady_d;
    end
  end

  // Key storage. With zeroize enabled, a clear wipes every word. Without it,
  // the stale words stay but are hidden behind the cleared valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        for (int w = 0; w < 4; w++) begin
          keyMem_q[s][w] <= '0;
        end
      end
    end else begin
`ifdef KEY_STORE_ZEROIZE_EN
      if (clearReq) begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
          for (int w = 0; w < 4; w++) begin
            keyMem_q[s][w] <= '0;
          end
        end
      end else if (wrReq) begin
        for (int w = 0; w < 4; w++) begin
          keyMem_q[core_count_in][w] <= keyIn[w];
        end
      end
`else
      if (wrReq) begin
        for (int w = 0; w < 4; w++) begin
          keyMem_q[core_count_in][w] <= keyIn[w];
        end
      end
`endif
    end
  end

  // Registered read port. It samples the current (pre-write, pre-clear)
  // contents, which gives read-before-write behaviour on a same-slot
  // collision. The data holds while no read is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdValid_q <= 1'b0;
      rdErr_q   <= 1'b0;
      for (int w = 0; w < 4; w++) begin
        rdKey_q[w] <= '0;
      end
    end else begin
      rdValid_q <= rd_en && rdHit;
      rdErr_q   <= rd_en && !rdHit;
      if (rd_en) begin
        for (int w = 0; w < 4; w++) begin
          rdKey_q[w] <= rdHit ? keyMem_q[rdSlot][w] : '0;
        end
      end
    end
  end

  assign rd_valid   = rdValid_q;
  assign rd_err     = rdErr_q;
  assign rd_key_0   = rdKey_q[0];
  assign rd_key_1   = rdKey_q[1];
  assign rd_key_2   = rdKey_q[2];
  assign rd_key_3   = rdKey_q[3];
  assign keys_ready = keysReady_q;

endmodule

// File: tb/tb_aes_round_key_store.sv
// ---------------------------------------------------------------------------
// tb_aes_round_key_store
//
// Self-checking bench for aes_round_key_store. It has three parts:
//   - a table of FIPS-197 schedule vectors with hand-computed expectations,
//   - hand-written sequences for partial fill, read/write collision and
//     asynchronous reset while a read is in flight,
//   - randomized traffic compared against a slot-array reference model.
// ---------------------------------------------------------------------------
module tb_aes_round_key_store;

  localparam int DW = 32;
  localparam int NR = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    FSM_core_in;
  logic [3:0]    core_count_in;
  logic [DW-1:0] key_in_0, key_in_1, key_in_2, key_in_3;
  logic          rd_en;
  logic [3:0]    rd_addr;
  logic          rd_rev;
  logic          rd_valid;
  logic [DW-1:0] rd_key_0, rd_key_1, rd_key_2, rd_key_3;
  logic          rd_err;
  logic          keys_ready;

  aes_round_key_store #(.DATA_WIDTH(DW), .NUM_ROUNDS(NR)) dut (
    .clk           (clk),
    .rst           (rst),
    .FSM_core_in   (FSM_core_in),
    .core_count_in (core_count_in),
    .key_in_0      (key_in_0),
    .key_in_1      (key_in_1),
    .key_in_2      (key_in_2),
    .key_in_3      (key_in_3),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_rev        (rd_rev),
    .rd_valid      (rd_valid),
    .rd_key_0      (rd_key_0),
    .rd_key_1      (rd_key_1),
    .rd_key_2      (rd_key_2),
    .rd_key_3      (rd_key_3),
    .rd_err        (rd_err),
    .keys_ready    (keys_ready)
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  // FIPS-197 appendix A.1 schedule for key 2b7e1516 28aed2a6 abf71588 09cf4f3c
  logic [127:0] fipsKey [0:10];

  // Reference model: one 128-bit entry and one valid flag per round slot
  logic [127:0] mdlMem   [0:NR];
  bit           mdlValid [0:NR];
  logic         mdlRdValid;
  logic         mdlRdErr;
  logic [127:0] mdlRdKey;

  typedef struct {
    string      name;
    logic [2:0] fsm;
    logic [3:0] cnt;
    int         keyIdx;
    logic       rdEn;
    logic [3:0] addr;
    logic       rev;
    logic       expValid;
    logic       expErr;
    logic       expReady;
    int         expKeyIdx;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(input string name, input logic [2:0] fsm, input logic [3:0] cnt,
                                 input int keyIdx, input logic rdEn, input logic [3:0] addr,
                                 input logic rev, input logic expValid, input logic expErr,
                                 input logic expReady, input int expKeyIdx);
    vec_t v;
    v.name = name; v.fsm = fsm; v.cnt = cnt; v.keyIdx = keyIdx;
    v.rdEn = rdEn; v.addr = addr; v.rev = rev;
    v.expValid = expValid; v.expErr = expErr; v.expReady = expReady; v.expKeyIdx = expKeyIdx;
    return v;
  endfunction

  // Index 0..10 selects a schedule entry; anything else means all-zero data
  function automatic logic [127:0] keyOf(input int idx);
    if (idx >= 0 && idx <= NR) return fipsKey[idx];
    return '0;
  endfunction

  function automatic logic [127:0] randKey();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic mdlAllValid();
    for (int i = 0; i <= NR; i++) begin
      if (!mdlValid[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic mdlReset();
    for (int i = 0; i <= NR; i++) begin
      mdlMem[i]   = '0;
      mdlValid[i] = 1'b0;
    end
    mdlRdValid = 1'b0;
    mdlRdErr   = 1'b0;
    mdlRdKey   = '0;
  endtask

  // One clock edge of the model using the inputs currently driven. The read
  // is resolved first, so it sees the state from before this edge's update.
  task automatic mdlStep();
    int slot;
    mdlRdValid = 1'b0;
    mdlRdErr   = 1'b0;
    if (rd_en) begin
      if (int'(rd_addr) > NR) begin
        mdlRdErr = 1'b1;
        mdlRdKey = '0;
      end else begin
        slot = rd_rev ? NR - int'(rd_addr) : int'(rd_addr);
        if (mdlValid[slot]) begin
          mdlRdValid = 1'b1;
          mdlRdKey   = mdlMem[slot];
        end else begin
          mdlRdErr = 1'b1;
          mdlRdKey = '0;
        end
      end
    end
    if (FSM_core_in == 3'b001) begin
      for (int i = 0; i <= NR; i++) begin
        mdlValid[i] = 1'b0;
`ifdef KEY_STORE_ZEROIZE_EN
        mdlMem[i] = '0;
`endif
      end
    end else if (FSM_core_in == 3'b010 && int'(core_count_in) <= NR) begin
      mdlMem[core_count_in]   = {key_in_0, key_in_1, key_in_2, key_in_3};
      mdlValid[core_count_in] = 1'b1;
    end
  endtask

  // Drive one cycle of inputs, advance the model, then sample point #1 after the edge
  task automatic applyStimulus(input logic [2:0] fsm, input logic [3:0] cnt, input logic [127:0] key,
                               input logic rdEn, input logic [3:0] addr, input logic rev);
    FSM_core_in   = fsm;
    core_count_in = cnt;
    {key_in_0, key_in_1, key_in_2, key_in_3} = key;
    rd_en   = rdEn;
    rd_addr = addr;
    rd_rev  = rev;
    mdlStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic expValid, input logic expErr,
                             input logic expReady, input logic [127:0] expKey);
    logic [130:0] act;
    logic [130:0] exp;
    act = {rd_valid, rd_err, keys_ready, rd_key_0, rd_key_1, rd_key_2, rd_key_3};
    exp = {expValid, expErr, expReady, expKey};
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got valid=%b err=%b ready=%b key=%h, expected valid=%b err=%b ready=%b key=%h",
               name, act[130], act[129], act[128], act[127:0], exp[130], exp[129], exp[128], exp[127:0]);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, mdlRdValid, mdlRdErr, mdlAllValid(), mdlRdKey);
  endtask

  task automatic setIdle();
    FSM_core_in   = 3'b000;
    core_count_in = 4'd0;
    {key_in_0, key_in_1, key_in_2, key_in_3} = '0;
    rd_en   = 1'b0;
    rd_addr = 4'd0;
    rd_rev  = 1'b0;
  endtask

  task automatic doReset();
    setIdle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    mdlReset();
    checkOutput("reset_state", 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
  endtask

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] keyA, keyB;
    int expHold;

    fipsKey[0]  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    fipsKey[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    fipsKey[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
    fipsKey[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
    fipsKey[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
    fipsKey[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
    fipsKey[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
    fipsKey[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
    fipsKey[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
    fipsKey[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
    fipsKey[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

    // ---------------- Table: full FIPS-197 schedule ----------------
    vecs.push_back(mkVec("clear_rd0", 3'b001, 4'd0, -1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, -1));
    for (int i = 0; i <= NR; i++) begin
      if (i == 1)
        vecs.push_back(mkVec("fill1_rd0", 3'b010, 4'(i), i, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0));
      else if (i == 2)
        vecs.push_back(mkVec("fill2_rd2_prewrite", 3'b010, 4'(i), i, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, -1));
      else begin
        expHold = (i == 0) ? -1 : (i >= 3 ? -1 : 0);
        vecs.push_back(mkVec($sformatf("fill%0d", i), 3'b010, 4'(i), i, 1'b0, 4'd0, 1'b0,
                             1'b0, 1'b0, (i == NR), expHold));
      end
    end
    vecs.push_back(mkVec("fwd_rd1",       3'b000, 4'd0, -1, 1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 1'b1, 1));
    vecs.push_back(mkVec("rev_rd0",       3'b000, 4'd0, -1, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 10));
    vecs.push_back(mkVec("rev_rd10",      3'b000, 4'd0, -1, 1'b1, 4'd10, 1'b1, 1'b1, 1'b0, 1'b1, 0));
    vecs.push_back(mkVec("rd15_range",    3'b000, 4'd0, -1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b1, 1'b1, -1));
    vecs.push_back(mkVec("rev_rd11_range",3'b000, 4'd0, -1, 1'b1, 4'd11, 1'b1, 1'b0, 1'b1, 1'b1, -1));
    vecs.push_back(mkVec("fwd_rd7",       3'b000, 4'd0, -1, 1'b1, 4'd7,  1'b0, 1'b1, 1'b0, 1'b1, 7));
    vecs.push_back(mkVec("idle_hold",     3'b000, 4'd0, -1, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 7));
    vecs.push_back(mkVec("clear_rd5_pre", 3'b001, 4'd0, -1, 1'b1, 4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 5));
    vecs.push_back(mkVec("post_clear_rd0",3'b000, 4'd0, -1, 1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, -1));
    vecs.push_back(mkVec("wr_cnt11_ign",  3'b010, 4'd11, 3, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, -1));
    vecs.push_back(mkVec("rd3_after_ign", 3'b000, 4'd0, -1, 1'b1, 4'd3,  1'b0, 1'b0, 1'b1, 1'b0, -1));

    rst = 1'b0;
    setIdle();
    #2;
    doReset();

    foreach (vecs[n]) begin
      applyStimulus(vecs[n].fsm, vecs[n].cnt, keyOf(vecs[n].keyIdx),
                    vecs[n].rdEn, vecs[n].addr, vecs[n].rev);
      checkOutput(vecs[n].name, vecs[n].expValid, vecs[n].expErr, vecs[n].expReady,
                  keyOf(vecs[n].expKeyIdx));
    end
`ifdef KEY_STORE_ZEROIZE_EN
    testsRun++;
    if ({dut.keyMem_q[10][0], dut.keyMem_q[10][1], dut.keyMem_q[10][2], dut.keyMem_q[10][3]} !== 128'h0) begin
      testsFailed++;
      $display("[TB] FAIL zeroize_slot10: got %h, expected 0",
               {dut.keyMem_q[10][0], dut.keyMem_q[10][1], dut.keyMem_q[10][2], dut.keyMem_q[10][3]});
    end
`endif

    // ---------------- Partial fill and collision ----------------
    doReset();
    keyA = '0;
    for (int i = 0; i <= 4; i++) begin
      if (i == 3) begin
        keyA = randKey();
        applyStimulus(3'b010, 4'(i), keyA, 1'b0, 4'd0, 1'b0);
      end else begin
        applyStimulus(3'b010, 4'(i), randKey(), 1'b0, 4'd0, 1'b0);
      end
      checkModel($sformatf("partial_fill%0d", i));
    end
    applyStimulus(3'b000, 4'd0, '0, 1'b1, 4'd7, 1'b0);
    checkOutput("partial_rd7", 1'b0, 1'b1, 1'b0, '0);
    applyStimulus(3'b000, 4'd0, '0, 1'b1, 4'd15, 1'b0);
    checkOutput("partial_rd15", 1'b0, 1'b1, 1'b0, '0);
    keyB = randKey();
    applyStimulus(3'b010, 4'd3, keyB, 1'b1, 4'd3, 1'b0);
    checkOutput("collision_old", 1'b1, 1'b0, 1'b0, keyA);
    applyStimulus(3'b000, 4'd0, '0, 1'b1, 4'd3, 1'b0);
    checkOutput("collision_new", 1'b1, 1'b0, 1'b0, keyB);
    // The rewrite must not have counted: after 5..9 there are 10 distinct slots
    for (int i = 5; i <= 9; i++) begin
      applyStimulus(3'b010, 4'(i), randKey(), 1'b0, 4'd0, 1'b0);
    end
    checkOutput("rewrite_no_count", 1'b0, 1'b0, 1'b0, keyB);
    applyStimulus(3'b010, 4'd10, randKey(), 1'b0, 4'd0, 1'b0);
    checkOutput("fill_complete", 1'b0, 1'b0, 1'b1, keyB);

    // ---------------- Asynchronous reset with a read in flight ----------------
    doReset();
    for (int i = 0; i <= 2; i++) begin
      applyStimulus(3'b010, 4'(i), randKey(), 1'b0, 4'd0, 1'b0);
    end
    applyStimulus(3'b010, 4'd3, randKey(), 1'b1, 4'd0, 1'b0);
    checkModel("pre_reset_rd0");
    FSM_core_in   = 3'b010;
    core_count_in = 4'd4;
    rd_en         = 1'b1;
    rd_addr       = 4'd1;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_immediate", 1'b0, 1'b0, 1'b0, '0);
    @(posedge clk);
    #1;
    checkOutput("async_reset_no_rdvalid", 1'b0, 1'b0, 1'b0, '0);
    setIdle();
    #2;
    rst = 1'b0;
    mdlReset();
    @(posedge clk);
    #1;
    applyStimulus(3'b000, 4'd0, '0, 1'b1, 4'd0, 1'b0);
    checkOutput("post_reset_rd0", 1'b0, 1'b1, 1'b0, '0);

    // ---------------- Randomized traffic against the model ----------------
    doReset();
    for (int c = 0; c < 600; c++) begin
      logic [2:0] fsm;
      logic [3:0] cnt;
      int r;
      r = $urandom_range(0, 99);
      if (r == 0)       fsm = 3'b001;
      else if (r < 75)  fsm = 3'b010;
      else begin
        fsm = 3'($urandom_range(0, 7));
        if (fsm == 3'b001 || fsm == 3'b010) fsm = 3'b000;
      end
      if ($urandom_range(0, 3) == 0) cnt = 4'($urandom_range(0, 15));
      else                           cnt = 4'($urandom_range(0, NR));
      applyStimulus(fsm, cnt, randKey(), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      checkModel($sformatf("random_%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
